uart_led_cmd_parser: RTL and testbench
======================================

// Module: uart_led_cmd_parser
// PURPOSE
//  Frame parser between the UART byte receiver and the LED pattern sequencer.
//  Assembles 8-byte command frames from the received byte stream.
//  On a valid frame it updates the registered Ctrl[7:0] pattern and Time[31:0]
//  step period that drive the LED sequencer. Malformed or stalled frames are
//  discarded and the previous outputs are held.
// PARAMETERS
//  HDR0          8'h55    first header byte
//  HDR1          8'hA5    second header byte
//  TAIL          8'hF0    tail byte
//  TIMEOUT_CLKS  500000   max Clk cycles between bytes inside a frame (10 ms @ 50 MHz)
//  TIME_RST      25000    reset value of Time output; must be nonzero
// PORTS
//  Clk          in   1   system clock
//  Reset_n      in   1   asynchronous reset, active-low
//  Rx_Data      in   8   received byte; valid only when Rx_Done=1
//  Rx_Done      in   1   one-cycle strobe: Rx_Data holds a new byte
//  Ctrl         out  8   LED pattern, bit7 shown first; registered
//  Time         out  32  LED step period in Clk cycles; registered
//  Frame_Valid  out  1   one-cycle pulse: Ctrl/Time just updated
//  Frame_Err    out  1   one-cycle pulse: frame discarded
// BEHAVIOUR
//  Frame on wire: HDR0 HDR1 T3 T2 T1 T0 CTRL TAIL; Time is MSB first.
//  Reset values: Ctrl=8'h00, Time=TIME_RST, Frame_Valid=0, Frame_Err=0, state IDLE.
//  Bytes are consumed only on cycles with Rx_Done=1. Other cycles never change
//    the state, except through the timeout.
//  FSM states: IDLE -> H1 -> B3 -> B2 -> B1 -> B0 -> CT -> TL -> IDLE.
//   IDLE: byte==HDR0 -> H1; any other byte is ignored silently.
//   H1:   byte==HDR1 -> B3; byte==HDR0 -> stay in H1 (resync);
//         any other byte -> IDLE, no error pulse.
//   B3..B0: load shadow time bytes in order. CT: load shadow ctrl.
//   TL:   byte==TAIL and shadow time != 0 -> commit; otherwise -> Frame_Err.
//         Both cases return to IDLE.
//  Commit: Ctrl/Time take the shadow values and Frame_Valid=1 on the cycle
//    after the Rx_Done of the TAIL byte (latency 1). Outputs are stable between
//    commits.
//  A shadow time of 0 is rejected, because the downstream block requires Time >= 1.
//  Timeout: the gap counter clears on every Rx_Done and counts only in states
//    other than IDLE. When it reaches TIMEOUT_CLKS-1: go to IDLE, pulse Frame_Err,
//    clear the counter.
//  Rx_Done in the same cycle as timeout expiry: the byte wins and the timeout
//    is cancelled.
//  Error in H1 (bad second header) does not pulse Frame_Err. Only tail, zero-time
//    and timeout failures do.
//  Frame_Valid and Frame_Err are never high in the same cycle.
//  Reset mid-frame: the shadow registers are discarded and the outputs return
//    to their reset values.
//  Shadow registers are not cleared on abort. They are fully overwritten by the
//    next frame before any commit.
// STRUCTURE
//  Package uart_led_pkg: HDR0/HDR1/TAIL defaults, FRAME_LEN=8,
//    state enum (IDLE,H1,B3,B2,B1,B0,CT,TL).
//  One sub-module, uart_byte_gap_timer. Inputs: Clk, Reset_n, clr (Rx_Done),
//    run (state != IDLE). Output: one-cycle expire.
//  The top level holds the FSM, the shadow registers and the output registers.
// TESTING
//  1. Send 55 A5 00 00 61 A8 B5 F0 -> Time=32'd25000, Ctrl=8'hB5,
//     Frame_Valid high 1 cycle after the last Rx_Done.
//  2. Send 55 55 A5 00 00 00 0A 3C F0 -> resync accepted: Time=10, Ctrl=8'h3C.
//  3. Send 55 A5 00 00 00 0A 3C 0F -> Frame_Err pulse; Ctrl/Time keep
//     their previous values.
//  4. Send 55 A5 00 00 00 00 FF F0 -> Frame_Err pulse (zero Time);
//     outputs unchanged.
//  5. Send 55 A5 00, then wait TIMEOUT_CLKS cycles -> Frame_Err at expiry,
//     state IDLE. Next, a full good frame commits normally. Also check an Rx_Done
//     exactly on the expiry cycle -> no error.
//  6. Assert Reset_n low during byte 5 of a frame -> Ctrl=0, Time=TIME_RST.
//     The remaining bytes of that frame produce no commit.

Source files
------------

// File: rtl/uart_led_pkg.sv
// Shared constants and state encoding for the UART LED command frame parser.
package uart_led_pkg;

    localparam logic [7:0] HDR0_DEFAULT = 8'h55;
    localparam logic [7:0] HDR1_DEFAULT = 8'hA5;
    localparam logic [7:0] TAIL_DEFAULT = 8'hF0;
    localparam int         FRAME_LEN    = 8;

    typedef enum logic [2:0] {
        IDLE,
        H1,
        B3,
        B2,
        B1,
        B0,
        CT,
        TL
    } parser_state_t;

endpackage

// File: rtl/uart_led_cmd_parser_if.sv
// Byte-receiver to parser link plus the parser's registered LED control outputs.
interface uart_led_cmd_parser_if;

    logic [7:0]  Rx_Data;
    logic        Rx_Done;
    logic [7:0]  Ctrl;
    logic [31:0] Time;
    logic        Frame_Valid;
    logic        Frame_Err;

    modport master (
        output Rx_Data, Rx_Done,
        input  Ctrl, Time, Frame_Valid, Frame_Err
    );

    modport slave (
        input  Rx_Data, Rx_Done,
        output Ctrl, Time, Frame_Valid, Frame_Err
    );

endinterface

// File: rtl/uart_byte_gap_timer.sv
// Inter-byte gap watchdog: flags a stalled frame after TIMEOUT_CLKS idle cycles.
module uart_byte_gap_timer #(
    parameter int TIMEOUT_CLKS = 500000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam int CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt;

    // A byte arriving on the expiry cycle cancels the timeout.
    assign expire = run && !clr && (cnt == LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (clr || !run || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_led_cmd_parser.sv
// Assembles 8-byte command frames and commits LED pattern/period on a valid frame.
module uart_led_cmd_parser
    import uart_led_pkg::*;
#(
    parameter logic [7:0]  HDR0         = HDR0_DEFAULT,
    parameter logic [7:0]  HDR1         = HDR1_DEFAULT,
    parameter logic [7:0]  TAIL         = TAIL_DEFAULT,
    parameter int          TIMEOUT_CLKS = 500000,
    parameter logic [31:0] TIME_RST     = 32'd25000
) (
    input logic                   Clk,
    input logic                   Reset_n,
    uart_led_cmd_parser_if.slave  bus
);

    parser_state_t state, state_next;
    logic          expire;
    logic          commit;
    logic          reject;
    logic [31:0]   shadow_time;
    logic [7:0]    shadow_ctrl;

    uart_byte_gap_timer #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_gap_timer (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (bus.Rx_Done),
        .run     (state != IDLE),
        .expire  (expire)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        reject     = 1'b0;
        if (bus.Rx_Done) begin
            case (state)
                IDLE: if (bus.Rx_Data == HDR0) state_next = H1;
                H1: begin
                    if (bus.Rx_Data == HDR1)      state_next = B3;
                    else if (bus.Rx_Data == HDR0) state_next = H1;
                    else                          state_next = IDLE;
                end
                B3: state_next = B2;
                B2: state_next = B1;
                B1: state_next = B0;
                B0: state_next = CT;
                CT: state_next = TL;
                TL: begin
                    state_next = IDLE;
                    // Downstream sequencer cannot run with a zero step period.
                    if (bus.Rx_Data == TAIL && shadow_time != 32'd0) commit = 1'b1;
                    else                                              reject = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end else if (expire) begin
            state_next = IDLE;
            reject     = 1'b1;
        end
    end

    // Shadows are only overwritten, never cleared on abort; every frame refills them.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow_time <= 32'd0;
            shadow_ctrl <= 8'h00;
        end else if (bus.Rx_Done) begin
            case (state)
                B3:      shadow_time[31:24] <= bus.Rx_Data;
                B2:      shadow_time[23:16] <= bus.Rx_Data;
                B1:      shadow_time[15:8]  <= bus.Rx_Data;
                B0:      shadow_time[7:0]   <= bus.Rx_Data;
                CT:      shadow_ctrl        <= bus.Rx_Data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.Ctrl        <= 8'h00;
            bus.Time        <= TIME_RST;
            bus.Frame_Valid <= 1'b0;
            bus.Frame_Err   <= 1'b0;
        end else begin
            bus.Frame_Valid <= commit;
            bus.Frame_Err   <= reject;
            if (commit) begin
                bus.Ctrl <= shadow_ctrl;
                bus.Time <= shadow_time;
            end
        end
    end

endmodule

// File: tb/tb_uart_led_cmd_parser.sv
// Directed frame table, timeout/reset corner cases and random traffic against a frame-buffer model.
module tb_uart_led_cmd_parser;
    import uart_led_pkg::*;

    localparam int          TIMEOUT  = 40;
    localparam logic [31:0] TIME_RST = 32'd25000;

    logic Clk;
    logic Reset_n;

    uart_led_cmd_parser_if bus ();

    uart_led_cmd_parser #(
        .TIMEOUT_CLKS (TIMEOUT),
        .TIME_RST     (TIME_RST)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]  data;
        logic        exp_valid;
        logic        exp_err;
        logic [7:0]  exp_ctrl;
        logic [31:0] exp_time;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain buffer of accepted frame bytes plus an idle-edge count.
    logic [7:0]  m_buf[FRAME_LEN];
    int          m_len;
    int          m_gap;
    logic        m_valid;
    logic        m_err;
    logic [7:0]  m_ctrl;
    logic [31:0] m_time;

    task automatic model_reset();
        m_len   = 0;
        m_gap   = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_ctrl  = 8'h00;
        m_time  = TIME_RST;
    endtask

    task automatic model_edge(input logic done, input logic [7:0] d);
        logic [31:0] t;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (done) begin
            m_gap = 0;
            if (m_len == 0) begin
                if (d == HDR0_DEFAULT) begin
                    m_buf[0] = d;
                    m_len    = 1;
                end
            end else if (m_len == 1) begin
                if (d == HDR1_DEFAULT) begin
                    m_buf[1] = d;
                    m_len    = 2;
                end else if (d != HDR0_DEFAULT) begin
                    m_len = 0;
                end
            end else begin
                m_buf[m_len] = d;
                m_len++;
                if (m_len == FRAME_LEN) begin
                    t = {m_buf[2], m_buf[3], m_buf[4], m_buf[5]};
                    if (m_buf[7] == TAIL_DEFAULT && t != 0) begin
                        m_valid = 1'b1;
                        m_ctrl  = m_buf[6];
                        m_time  = t;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_len = 0;
                end
            end
        end else if (m_len != 0) begin
            m_gap++;
            if (m_gap == TIMEOUT) begin
                m_err = 1'b1;
                m_len = 0;
                m_gap = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output(input string tag, input logic v, input logic e,
                                input logic [7:0] c, input logic [31:0] t);
        check({tag, ".Frame_Valid"}, 32'(bus.Frame_Valid), 32'(v));
        check({tag, ".Frame_Err"},   32'(bus.Frame_Err),   32'(e));
        check({tag, ".Ctrl"},        32'(bus.Ctrl),        32'(c));
        check({tag, ".Time"},        bus.Time,             t);
    endtask

    task automatic check_model(input string tag);
        check_output(tag, m_valid, m_err, m_ctrl, m_time);
    endtask

    task automatic apply_stimulus(input logic done, input logic [7:0] d);
        bus.Rx_Done = done;
        bus.Rx_Data = d;
        @(posedge Clk);
        model_edge(done, d);
        #1;
        bus.Rx_Done = 1'b0;
    endtask

    task automatic send_checked(input logic [7:0] d, input string tag);
        apply_stimulus(1'b1, d);
        check_model(tag);
    endtask

    task automatic idle_checked(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 8'h00);
            check_model(tag);
        end
    endtask

    task automatic add_vec(input logic [7:0] d, input logic v, input logic e,
                           input logic [7:0] c, input logic [31:0] t);
        vec_t x;
        x.data = d; x.exp_valid = v; x.exp_err = e; x.exp_ctrl = c; x.exp_time = t;
        vecs.push_back(x);
    endtask

    task automatic add_bytes(input logic [7:0] b[], input logic [7:0] c, input logic [31:0] t);
        foreach (b[i]) add_vec(b[i], 1'b0, 1'b0, c, t);
    endtask

    initial begin
        logic [7:0]  fr[8];
        logic [31:0] rt;
        int          gap;

        bus.Rx_Done = 1'b0;
        bus.Rx_Data = 8'h00;
        Reset_n     = 1'b0;
        model_reset();
        #12;
        check_output("reset", 1'b0, 1'b0, 8'h00, TIME_RST);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed frames with hand-derived expectations
        add_bytes('{8'h55, 8'hA5, 8'h00, 8'h00, 8'h61, 8'hA8, 8'hB5}, 8'h00, TIME_RST);
        add_vec(8'hF0, 1'b1, 1'b0, 8'hB5, 32'd25000);
        add_bytes('{8'h55, 8'h55, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h3C}, 8'hB5, 32'd25000);
        add_vec(8'hF0, 1'b1, 1'b0, 8'h3C, 32'd10);
        add_bytes('{8'h55, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h3C}, 8'h3C, 32'd10);
        add_vec(8'h0F, 1'b0, 1'b1, 8'h3C, 32'd10);
        add_bytes('{8'h55, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}, 8'h3C, 32'd10);
        add_vec(8'hF0, 1'b0, 1'b1, 8'h3C, 32'd10);
        add_bytes('{8'h55, 8'h12}, 8'h3C, 32'd10);
        add_bytes('{8'h55, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h81}, 8'h3C, 32'd10);
        add_vec(8'hF0, 1'b1, 1'b0, 8'h81, 32'd256);

        foreach (vecs[i]) begin
            apply_stimulus(1'b1, vecs[i].data);
            check_output($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_err,
                         vecs[i].exp_ctrl, vecs[i].exp_time);
        end

        // Stalled frame expires after TIMEOUT idle edges
        send_checked(8'h55, "to_h0");
        send_checked(8'hA5, "to_h1");
        send_checked(8'h00, "to_b3");
        idle_checked(TIMEOUT - 1, "to_wait");
        apply_stimulus(1'b0, 8'h00);
        check_output("timeout_expiry", 1'b0, 1'b1, 8'h81, 32'd256);
        apply_stimulus(1'b0, 8'h00);
        check_output("timeout_after", 1'b0, 1'b0, 8'h81, 32'd256);
        foreach (fr[i]) fr[i] = 8'h00;
        fr = '{8'h55, 8'hA5, 8'h00, 8'h00, 8'h12, 8'h34, 8'hC3, 8'hF0};
        for (int i = 0; i < 7; i++) send_checked(fr[i], "post_to");
        apply_stimulus(1'b1, fr[7]);
        check_output("post_to_commit", 1'b1, 1'b0, 8'hC3, 32'h1234);

        // Byte on the exact expiry cycle cancels the timeout
        send_checked(8'h55, "ex_h0");
        send_checked(8'hA5, "ex_h1");
        send_checked(8'h00, "ex_b3");
        idle_checked(TIMEOUT - 1, "ex_wait");
        apply_stimulus(1'b1, 8'h00);
        check_output("expiry_byte_wins", 1'b0, 1'b0, 8'hC3, 32'h1234);
        send_checked(8'h00, "ex_b1");
        send_checked(8'h07, "ex_b0");
        send_checked(8'h5A, "ex_ct");
        apply_stimulus(1'b1, 8'hF0);
        check_output("expiry_commit", 1'b1, 1'b0, 8'h5A, 32'd7);

        // Reset asserted during byte 5 of a frame
        send_checked(8'h55, "rst_h0");
        send_checked(8'hA5, "rst_h1");
        send_checked(8'h00, "rst_b3");
        send_checked(8'h00, "rst_b2");
        bus.Rx_Data = 8'h09;
        bus.Rx_Done = 1'b1;
        #2 Reset_n = 1'b0;
        #1;
        check_output("midframe_reset", 1'b0, 1'b0, 8'h00, TIME_RST);
        model_reset();
        @(negedge Clk);
        bus.Rx_Done = 1'b0;
        Reset_n     = 1'b1;
        apply_stimulus(1'b1, 8'h20);
        check_output("rst_rest0", 1'b0, 1'b0, 8'h00, TIME_RST);
        apply_stimulus(1'b1, 8'h33);
        check_output("rst_rest1", 1'b0, 1'b0, 8'h00, TIME_RST);
        apply_stimulus(1'b1, 8'hF0);
        check_output("rst_rest_tail", 1'b0, 1'b0, 8'h00, TIME_RST);
        fr = '{8'h55, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h63, 8'hE7, 8'hF0};
        for (int i = 0; i < 7; i++) send_checked(fr[i], "rst_good");
        apply_stimulus(1'b1, fr[7]);
        check_output("rst_good_commit", 1'b1, 1'b0, 8'hE7, 32'd99);

        // Random traffic: mostly near-valid frames with occasional corruption and stalls
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                fr[0] = HDR0_DEFAULT;
                fr[1] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : HDR1_DEFAULT;
                fr[2] = rt[31:24];
                fr[3] = rt[23:16];
                fr[4] = rt[15:8];
                fr[5] = rt[7:0];
                fr[6] = 8'($urandom);
                fr[7] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : TAIL_DEFAULT;
                for (int i = 0; i < FRAME_LEN; i++) begin
                    if ($urandom_range(0, 30) == 0) gap = TIMEOUT - 1 + $urandom_range(0, 2);
                    else                            gap = $urandom_range(0, 2);
                    idle_checked(gap, "rnd_gap");
                    send_checked(fr[i], "rnd_frame");
                end
            end else begin
                for (int i = 0; i < $urandom_range(1, 6); i++) begin
                    case ($urandom_range(0, 4))
                        0: send_checked(HDR0_DEFAULT, "rnd_junk");
                        1: send_checked(HDR1_DEFAULT, "rnd_junk");
                        2: send_checked(TAIL_DEFAULT, "rnd_junk");
                        3: idle_checked($urandom_range(1, 3), "rnd_idle");
                        default: send_checked(8'($urandom), "rnd_junk");
                    endcase
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
